// File: rtl/matgen_pkg.sv
// Shared definitions for the matrix-multiply instruction sequencer:
// MIPS opcodes, function codes, register numbers, FSM state type and
// small word-packing helpers.
// Optional feature macro: MATGEN_NOP_EN adds a NOP state after LDB.
package matgen_pkg;

  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_SPECIAL = 6'h00;

  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_ADD = 6'h20;

  // $16 holds A element, $17 B element, $18 product, $19 accumulator,
  // $23 is the (zero) base register for absolute addressing.
  localparam logic [4:0] R_A    = 5'd16;
  localparam logic [4:0] R_B    = 5'd17;
  localparam logic [4:0] R_P    = 5'd18;
  localparam logic [4:0] R_ACC  = 5'd19;
  localparam logic [4:0] R_BASE = 5'd23;

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    LDA,
    LDB,
`ifdef MATGEN_NOP_EN
    NOP,
`endif
    MUL,
    ADD,
    STORE,
    FIN
  } state_t;

  // I-type word: opcode | rs | rt | imm16
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // R-type word under SPECIAL opcode with zero shift amount
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OP_SPECIAL, rs, rt, rd, 5'd0, funct};
  endfunction

endpackage

// File: rtl/matgen_encoder.sv
// Combinational instruction formatter: turns the sequencer state and the
// current operand address into one MIPS instruction word. States that do
// not emit a word (IDLE, FIN, and the optional NOP bubble) produce zero.
module matgen_encoder
  import matgen_pkg::*;
(
  input  state_t      state,
  input  logic [15:0] addr,
  output logic [31:0] instr
);

  // Select the word layout for the current state
  always_comb begin
    instr = '0;
    case (state)
      CLR:     instr = enc_i(OP_ADDI, R_BASE, R_ACC, 16'd0);
      LDA:     instr = enc_i(OP_LW, R_BASE, R_A, addr);
      LDB:     instr = enc_i(OP_LW, R_BASE, R_B, addr);
      MUL:     instr = enc_r(R_A, R_B, R_P, FN_MUL);
      ADD:     instr = enc_r(R_P, R_ACC, R_ACC, FN_ADD);
      STORE:   instr = enc_i(OP_SW, R_BASE, R_ACC, addr);
      default: instr = '0;
    endcase
  end

endmodule

// File: rtl/matgen_instr_seq.sv
// Instruction sequencer that streams a complete C = A*B program for
// N x N word matrices to a MIPS-style ALU core over a valid/ready link.
// Per element (i,j), row-major: CLR, then for each k LDA/LDB/MUL/ADD,
// then STORE. Outputs are decoded from the state register so an
// asynchronous reset clears them immediately.
// Optional feature macro: MATGEN_NOP_EN inserts a load-use NOP after LDB.
module matgen_instr_seq
  import matgen_pkg::*;
#(
  parameter int N      = 3,   // 1..15
  parameter int A_BASE = 0,
  parameter int B_BASE = 9,
  parameter int C_BASE = 18   // C_BASE + N*N - 1 must fit in 16 bits
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] LAST = 4'(N - 1);

  state_t      state, state_n;
  logic [3:0]  i, j, k;
  logic [3:0]  i_n, j_n, k_n;
  logic [15:0] addr;
  logic        xfer;

  assign instr_valid = (state != IDLE) && (state != FIN);
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign xfer        = instr_valid && instr_ready;

  // Operand address for the word currently presented (row-major layout)
  always_comb begin
    addr = 16'd0;
    case (state)
      LDA:     addr = 16'(A_BASE) + 16'(i) * 16'(N) + 16'(k);
      LDB:     addr = 16'(B_BASE) + 16'(k) * 16'(N) + 16'(j);
      STORE:   addr = 16'(C_BASE) + 16'(i) * 16'(N) + 16'(j);
      default: addr = 16'd0;
    endcase
  end

  matgen_encoder u_enc (
    .state (state),
    .addr  (addr),
    .instr (instr)
  );

  // State and loop-index registers; reset aborts any program in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
    end else begin
      state <= state_n;
      i     <= i_n;
      j     <= j_n;
      k     <= k_n;
    end
  end

  // Next-state and index update; word states advance only on a transfer
  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    k_n     = k;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = CLR;
          i_n     = '0;
          j_n     = '0;
          k_n     = '0;
        end
      end
      CLR:  if (xfer) state_n = LDA;
      LDA:  if (xfer) state_n = LDB;
`ifdef MATGEN_NOP_EN
      LDB:  if (xfer) state_n = NOP;
      NOP:  if (xfer) state_n = MUL;
`else
      LDB:  if (xfer) state_n = MUL;
`endif
      MUL:  if (xfer) state_n = ADD;
      ADD: begin
        if (xfer) begin
          if (k == LAST) begin
            state_n = STORE;
          end else begin
            k_n     = k + 4'd1;
            state_n = LDA;
          end
        end
      end
      STORE: begin
        if (xfer) begin
          k_n = '0;
          if (j != LAST) begin
            j_n     = j + 4'd1;
            state_n = CLR;
          end else if (i != LAST) begin
            i_n     = i + 4'd1;
            j_n     = '0;
            state_n = CLR;
          end else begin
            state_n = FIN;
          end
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matgen_instr_seq.sv
// Self-checking bench for matgen_instr_seq: a default N=3 instance and an
// N=1, C_BASE=2 instance, checked against a word-index model of the program.
module tb_matgen_instr_seq;

`ifdef MATGEN_NOP_EN
  localparam int KW = 5;
`else
  localparam int KW = 4;
`endif
  localparam int EW3  = KW * 3 + 2;
  localparam int TOT3 = 9 * EW3;
  localparam int TOT1 = KW + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start3 = 1'b0, rdy3 = 1'b1;
  logic        start1 = 1'b0, rdy1 = 1'b1;
  logic [31:0] instr3, instr1;
  logic        valid3, valid1, busy3, busy1, done3, done1;

  int n_chk = 0;
  int n_fail = 0;
  int idx3 = 0, idx1 = 0;
  int done3_cnt = 0, done1_cnt = 0;
  logic [31:0] got3 [0:255];
  logic [31:0] got1 [0:15];

  always #5 clk = ~clk;

  matgen_instr_seq dut3 (
    .clk(clk), .rst(rst), .start(start3), .instr(instr3), .instr_valid(valid3),
    .instr_ready(rdy3), .busy(busy3), .done(done3)
  );

  matgen_instr_seq #(.N(1), .A_BASE(0), .B_BASE(9), .C_BASE(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .instr(instr1), .instr_valid(valid1),
    .instr_ready(rdy1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Word w of the program, derived from the element/k position of w
  function automatic logic [31:0] model(input int n, input int ab, input int bb,
                                        input int cb, input int w);
    int ew, e, r, i, j, k, p;
    ew = KW * n + 2;
    e  = w / ew;
    r  = w % ew;
    i  = e / n;
    j  = e % n;
    if (r == 0) return 32'h22F30000;
    if (r == ew - 1) return 32'hAEF30000 | 32'(cb + i * n + j);
    k = (r - 1) / KW;
    p = (r - 1) % KW;
    if (p == 0) return 32'h8EF00000 | 32'(ab + i * n + k);
    if (p == 1) return 32'h8EF10000 | 32'(bb + k * n + j);
    if (p == KW - 2) return 32'h02119018;
    if (p == KW - 1) return 32'h02539820;
    return 32'h00000000;
  endfunction

  // Compare process: every cycle, presented words against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        idx3 = 0;
        idx1 = 0;
      end else begin
        if (valid3) begin
          if (idx3 >= TOT3) chk("dut3_overrun", idx3, TOT3 - 1);
          else chk("dut3_word", instr3, model(3, 0, 9, 18, idx3));
          if (rdy3) begin
            if (idx3 < 256) got3[idx3] = instr3;
            idx3++;
          end
        end else begin
          chk("dut3_idle_instr", instr3, 32'h0);
        end
        if (done3) begin
          done3_cnt++;
          chk("dut3_xfer_total", idx3, TOT3);
          idx3 = 0;
        end
        if (valid1) begin
          if (idx1 >= TOT1) chk("dut1_overrun", idx1, TOT1 - 1);
          else chk("dut1_word", instr1, model(1, 0, 9, 2, idx1));
          if (rdy1) begin
            if (idx1 < 16) got1[idx1] = instr1;
            idx1++;
          end
        end else begin
          chk("dut1_idle_instr", instr1, 32'h0);
        end
        if (done1) begin
          done1_cnt++;
          chk("dut1_xfer_total", idx1, TOT1);
          idx1 = 0;
        end
      end
    end
  end

  task automatic start_dut3();
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    chk("start_first_word", instr3, 32'h22F30000);
    chk("start_valid", valid3, 1'b1);
  endtask

  // Run dut3 with optional stall on one word or reset at a word index
  task automatic run3(input int stall_at, input int stall_len, input int rst_at);
    int  stalled = 0;
    int  prev = done3_cnt;
    bit  fin = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(posedge clk); #1;
      if (done3_cnt != prev) begin
        fin = 1'b1;
      end else if (rst_at >= 0 && idx3 == rst_at && busy3) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_async_instr", instr3, 32'h0);
        chk("rst_async_valid", valid3, 1'b0);
        chk("rst_async_busy", busy3, 1'b0);
        chk("rst_async_done", done3, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        rdy3 = 1'b1;
        return;
      end else if (idx3 == stall_at && stalled < stall_len) begin
        rdy3 = 1'b0;
        stalled++;
        chk("stall_instr", instr3, 32'h8EF10009);
        chk("stall_valid", valid3, 1'b1);
      end else begin
        rdy3 = 1'b1;
      end
    end
    rdy3 = 1'b1;
    chk("dut3_done_seen", fin, 1'b1);
    chk("dut3_busy_after_done", busy3, 1'b0);
    chk("dut3_done_one_cycle", done3, 1'b0);
  endtask

  initial begin
    int prev;
    bit fin;
    logic [31:0] head [0:5];
    int base;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_instr", instr3, 32'h0);
    chk("reset_valid", valid3, 1'b0);
    chk("reset_busy", busy3, 1'b0);
    chk("reset_done", done3, 1'b0);
    chk("reset_busy_n1", busy1, 1'b0);
    rst = 1'b0;

    // Model pins
    chk("model_w0", model(3, 0, 9, 18, 0), 32'h22F30000);
    chk("model_w2", model(3, 0, 9, 18, 2), 32'h8EF10009);
    chk("model_store00", model(3, 0, 9, 18, EW3 - 1), 32'hAEF30012);

    // Full program with 5-cycle backpressure on word 2
    start_dut3();
    run3(2, 5, -1);
`ifndef MATGEN_NOP_EN
    head = '{32'h22F30000, 32'h8EF00000, 32'h8EF10009, 32'h02119018, 32'h02539820, 32'h8EF00001};
    for (int w = 0; w < 6; w++) chk("head_word", got3[w], head[w]);
`endif
    chk("store00_word", got3[EW3 - 1], 32'hAEF30012);
    base = 5 * EW3;
    chk("e12_lwa_k0", got3[base + 1], 32'h8EF00003);
    chk("e12_lwa_k1", got3[base + 1 + KW], 32'h8EF00004);
    chk("e12_lwa_k2", got3[base + 1 + 2 * KW], 32'h8EF00005);
    chk("e12_lwb_k0", got3[base + 2], 32'h8EF1000B);
    chk("e12_lwb_k1", got3[base + 2 + KW], 32'h8EF1000E);
    chk("e12_lwb_k2", got3[base + 2 + 2 * KW], 32'h8EF10011);
    chk("e12_sw", got3[base + EW3 - 1], 32'hAEF30017);

    // Reset mid-program at transfer 40, then no resume, then fresh start
    start_dut3();
    run3(-1, 0, 40);
    repeat (3) @(posedge clk);
    #1;
    chk("no_resume_busy", busy3, 1'b0);
    chk("no_resume_valid", valid3, 1'b0);
    start_dut3();
    run3(-1, 0, -1);
    chk("dut3_done_count", done3_cnt, 2);

    // N=1, C_BASE=2 with start held during busy
    @(posedge clk); #1 start1 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    start1 = 1'b0;
    prev = done1_cnt;
    fin = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(posedge clk); #1;
      if (done1_cnt != prev) fin = 1'b1;
    end
    chk("n1_done_seen", fin, 1'b1);
    chk("n1_busy_after_done", busy1, 1'b0);
`ifndef MATGEN_NOP_EN
    head = '{32'h22F30000, 32'h8EF00000, 32'h8EF10009, 32'h02119018, 32'h02539820, 32'hAEF30002};
    for (int w = 0; w < 6; w++) chk("n1_word", got1[w], head[w]);
`endif
    repeat (5) begin
      @(posedge clk); #1;
      chk("n1_no_restart", busy1, 1'b0);
    end
    chk("n1_done_count", done1_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/matgen_instr_seq.md
MATGEN_INSTR_SEQ -- requirements
Module: matgen_instr_seq

Interface
REQ-001 SHALL have parameter N, default 3, meaning square matrix dimension; legal range 1..15.
REQ-002 SHALL have parameter A_BASE, default 0, meaning word address of A[0][0], row-major.
REQ-003 SHALL have parameter B_BASE, default 9, meaning word address of B[0][0], row-major.
REQ-004 SHALL have parameter C_BASE, default 18, meaning word address of C[0][0], row-major; C_BASE+N*N-1 SHALL be at most 65535.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1, meaning begin one C=A*B program when idle.
REQ-008 SHALL have port instr, output, 32, meaning MIPS-format instruction word to the ALU core.
REQ-009 SHALL have port instr_valid, output, 1, meaning instr holds a word to be consumed.
REQ-010 SHALL have port instr_ready, input, 1, meaning the core accepts instr this cycle.
REQ-011 SHALL have port busy, output, 1, meaning a program is in progress.
REQ-012 SHALL have port done, output, 1, meaning one-cycle pulse after the last store is accepted.

Function
REQ-013 SHALL transfer a word only on a cycle with instr_valid and instr_ready both high.
REQ-014 SHALL hold instr stable, with instr_valid high, while instr_ready is low.
REQ-015 SHALL use FSM states IDLE, CLR, LDA, LDB, MUL, ADD, STORE, FIN; each non-IDLE/FIN state emits one word and advances only on transfer.
REQ-016 SHALL encode CLR as addi $19,$23,0 (0x22F30000).
REQ-017 SHALL encode LDA as lw $16,(A_BASE+i*N+k)($23), and LDB as lw $17,(B_BASE+k*N+j)($23).
REQ-018 SHALL encode MUL as 0x02119018 ($18=$16*$17, funct 011000), and ADD as 0x02539820 ($19=$18+$19).
REQ-019 SHALL encode STORE as sw $19,(C_BASE+i*N+j)($23); immediates are 16-bit, zero-extended addresses.
REQ-020 SHALL transition ADD->STORE when k==N-1, else increment k and go to LDA.
REQ-021 SHALL transition STORE->CLR with j+1 (k=0) when j<N-1; with i+1, j=0 when j==N-1 and i<N-1; to FIN when i==N-1 and j==N-1.
REQ-022 SHALL order elements row-major (i outer, j inner) and emit N*N*(4N+2) words per program.
REQ-023 SHALL pulse done for exactly one cycle in FIN, then return to IDLE.
REQ-024 SHALL enter CLR from IDLE on start with i=j=k=0, and SHALL drive instr_valid high in that same cycle.
REQ-025 SHALL ignore start while busy or in FIN; SHALL drive busy high in all states except IDLE.
REQ-026 SHALL drive instr to 0 and instr_valid low in IDLE and FIN.

Reset
REQ-027 SHALL on rst, immediately and at any point in a program, force IDLE, i=j=k=0, instr=0, instr_valid=0, busy=0, done=0.
REQ-028 SHALL NOT resume an aborted program after rst; a new start is required.

Configuration
REQ-029 SHALL, when MATGEN_NOP_EN is defined, insert state NOP between LDB and MUL, emitting 0x00000000 as a load-use bubble, giving N*N*(5N+2) words per program.
REQ-030 SHALL, without MATGEN_NOP_EN, go LDB->MUL directly and contain no NOP state logic.

Structure
REQ-031 SHALL place opcodes (0x08, 0x23, 0x2B, 0x00), functs (0x18, 0x20), register numbers ($16,$17,$18,$19,$23) and the FSM state typedef in shared package matgen_pkg.
REQ-032 SHALL implement word formatting in one combinational sub-module matgen_encoder, which takes state and address and returns instr.

Verification
REQ-033 SHALL check default N=3 with ready tied high: words 0..5 are 0x22F30000, 0x8EF00000, 0x8EF10009, 0x02119018, 0x02539820, 0x8EF00001; word 13 is 0xAEF30012.
REQ-034 SHALL check that N=3 emits exactly 126 transfers and done pulses once, with busy low on the following cycle; with MATGEN_NOP_EN it emits 153 transfers.
REQ-035 SHALL check backpressure: hold instr_ready low for 5 cycles on word 2, then instr stays 0x8EF10009 and valid stays high, and no word is skipped or duplicated.
REQ-036 SHALL check element (1,2): lw A addresses 3,4,5, lw B addresses 11,14,17, and sw 0xAEF30017.
REQ-037 SHALL check rst asserted mid-program at transfer 40: outputs clear asynchronously, and a fresh start restarts at 0x22F30000.
REQ-038 SHALL check N=1 with C_BASE=2: program is 0x22F30000, 0x8EF00000, 0x8EF10009, 0x02119018, 0x02539820, 0xAEF30002, followed by a done pulse; start pulses during busy are ignored.
